// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed, active-low seven-segment display bus.
// Qualifies anode selects, samples each digit once after it has settled,
// assembles frames, and publishes a frame once it has repeated enough times.
// Declares the display idle after a long absence of valid anode selects.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYC    = 3,
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] word,
    output logic                    word_stb,
    output logic                    active,
    output logic                    err
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int KW = $clog2(STABLE_FRAMES + 1);
    localparam int FW = 4 * NUM_DIGITS;

    localparam logic [SW-1:0]         SETTLE_LAST  = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]         TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [KW-1:0]         STABLE_MAX   = KW'(STABLE_FRAMES);
    localparam logic [NUM_DIGITS-1:0] MASK_FULL    = '1;
    localparam logic [NUM_DIGITS-1:0] ONE_D        = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [FW-1:0]         BLANK        = '1;

    // Anode qualification
    logic [NUM_DIGITS-1:0] an_low;
    logic                  an_valid;
    logic                  an_same;

    // Settle / capture state
    logic [NUM_DIGITS-1:0] an_prev_reg;
    logic [SW-1:0]         settle_reg, settle_next;
    logic                  taken_reg, taken_next;
    logic                  capture;

    // Timeout state
    logic [TW-1:0]         to_reg, to_next;
    logic                  timeout;

    // Segment decode
    logic [3:0]            code;
    logic                  code_bad;

    // Frame assembly and stability
    logic [NUM_DIGITS-1:0] mask_reg, mask_next, mask_base;
    logic [FW-1:0]         frame_reg, frame_next;
    logic [FW-1:0]         last_reg, last_next;
    logic [KW-1:0]         stable_reg, stable_next;
    logic                  complete;
    logic                  drop;

    // Published outputs
    logic [FW-1:0]         word_reg, word_next;
    logic                  word_stb_reg, stb_next;
    logic                  active_reg, active_next;
    logic                  err_reg, err_next;

    // An anode select is valid when exactly one line is pulled low
    assign an_low   = ~an;
    assign an_valid = (an_low != '0) && ((an_low & (an_low - ONE_D)) == '0);
    assign an_same  = (an == an_prev_reg);

    // Map the active-low segment pattern back to its status-letter code
    always_comb begin
        code = 4'hE;
        case (seg)
            7'b1110001: code = 4'h0;  // L
            7'b1000001: code = 4'h1;  // U
            7'b0111000: code = 4'h2;  // F
            7'b0000001: code = 4'h3;  // O
            7'b0011000: code = 4'h4;  // P
            7'b0110000: code = 4'h5;  // E
            7'b1101010: code = 4'h6;  // N
            7'b1111111: code = 4'hF;  // blank
            default:    code = 4'hE;  // unrecognised pattern
        endcase
    end
    assign code_bad = (code == 4'hE);

    // Settle counter and one-shot capture per anode dwell
    always_comb begin
        settle_next = '0;
        if (an_valid && an_same) begin
            if (settle_reg != SETTLE_LAST)
                settle_next = settle_reg + SW'(1);
            else
                settle_next = settle_reg;
        end
        // taken_reg only matters while the same anode keeps dwelling
        capture    = an_valid && (settle_next == SETTLE_LAST) && !(an_same && taken_reg);
        taken_next = capture || (an_valid && an_same && taken_reg);
    end

    // Idle detection: saturating count of cycles without a valid anode
    always_comb begin
        if (an_valid)
            to_next = '0;
        else if (to_reg != TIMEOUT_LAST)
            to_next = to_reg + TW'(1);
        else
            to_next = to_reg;
        timeout = (to_next == TIMEOUT_LAST) && (to_reg != TIMEOUT_LAST);
    end

    // A full mask is seen for one cycle; it is consumed on the following edge
    assign complete  = (mask_reg == MASK_FULL);
    assign mask_base = complete ? '0 : mask_reg;
    assign drop      = capture && an_low[0] && (mask_base != '0);

    // Per-slot write of the captured code into the frame buffer
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
        assign frame_next[4*gi +: 4] = (capture && an_low[gi]) ? code : frame_reg[4*gi +: 4];
    end

    // Frame completion, stability tracking, publishing and idle handling
    always_comb begin
        mask_next   = mask_base;
        last_next   = last_reg;
        stable_next = stable_reg;
        word_next   = word_reg;
        stb_next    = 1'b0;
        active_next = active_reg;
        if (complete) begin
            if (frame_reg == last_reg) begin
                if (stable_reg != STABLE_MAX)
                    stable_next = stable_reg + KW'(1);
            end else begin
                stable_next = KW'(1);
                last_next   = frame_reg;
            end
            if ((stable_next == STABLE_MAX) && (frame_reg != word_reg)) begin
                word_next = frame_reg;
                stb_next  = 1'b1;
            end
        end
        if (capture) begin
            // Digit 0 always opens a fresh frame
            mask_next   = an_low[0] ? an_low : (mask_base | an_low);
            active_next = 1'b1;
        end
        // Timeout cannot coincide with a capture, which needs a valid anode
        if (timeout) begin
            mask_next   = '0;
            stable_next = '0;
            active_next = 1'b0;
            word_next   = BLANK;
            stb_next    = (word_reg != BLANK);
        end
    end

    assign err_next = capture && (code_bad || drop);

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            an_prev_reg  <= '1;
            settle_reg   <= '0;
            taken_reg    <= 1'b0;
            to_reg       <= '0;
            mask_reg     <= '0;
            frame_reg    <= BLANK;
            last_reg     <= BLANK;
            stable_reg   <= '0;
            word_reg     <= BLANK;
            word_stb_reg <= 1'b0;
            active_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            an_prev_reg  <= an;
            settle_reg   <= settle_next;
            taken_reg    <= taken_next;
            to_reg       <= to_next;
            mask_reg     <= mask_next;
            frame_reg    <= frame_next;
            last_reg     <= last_next;
            stable_reg   <= stable_next;
            word_reg     <= word_next;
            word_stb_reg <= stb_next;
            active_reg   <= active_next;
            err_reg      <= err_next;
        end
    end

    assign word     = word_reg;
    assign word_stb = word_stb_reg;
    assign active   = active_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scans followed by random
// scans, compared against a capture-level reference model.
module tb_seg_scan_decoder;
    localparam int SETTLE = 3;
    localparam int STABLE = 2;
    localparam int TMO    = 1024;

    localparam logic [6:0] S_L   = 7'b1110001;
    localparam logic [6:0] S_U   = 7'b1000001;
    localparam logic [6:0] S_F   = 7'b0111000;
    localparam logic [6:0] S_O   = 7'b0000001;
    localparam logic [6:0] S_P   = 7'b0011000;
    localparam logic [6:0] S_E   = 7'b0110000;
    localparam logic [6:0] S_N   = 7'b1101010;
    localparam logic [6:0] S_BL  = 7'b1111111;
    localparam logic [6:0] S_BAD = 7'b0101010;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] word;
    logic        word_stb, active, err;

    seg_scan_decoder #(
        .NUM_DIGITS(4), .SETTLE_CYC(SETTLE), .STABLE_FRAMES(STABLE), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg),
        .word(word), .word_stb(word_stb), .active(active), .err(err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int stb_seen = 0;
    int err_seen = 0;

    // Pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (word_stb) stb_seen++;
            if (err) err_seen++;
        end
    end

    // Reference decode table
    logic [6:0] seg_tab  [8] = '{S_L, S_U, S_F, S_O, S_P, S_E, S_N, S_BL};
    logic [3:0] code_tab [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};

    // Reference model state
    logic [3:0]  m_mask;
    logic [15:0] m_frame, m_last, m_word;
    int          m_stable;
    logic        m_active;
    int          exp_stb = 0;
    int          exp_err = 0;
    int          idle_run;

    logic [6:0]  rf [4];
    int          nd, dw, gp;

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        logic [3:0] c = 4'hE;
        for (int i = 0; i < 8; i++) if (s == seg_tab[i]) c = code_tab[i];
        return c;
    endfunction

    function automatic void model_reset();
        m_mask = '0; m_frame = '1; m_last = '1; m_word = '1;
        m_stable = 0; m_active = 1'b0; idle_run = 0;
    endfunction

    function automatic void model_capture(input int d, input logic [3:0] c);
        logic dropped = (d == 0) && (m_mask != 4'h0);
        if (dropped || c == 4'hE) exp_err++;
        if (d == 0) m_mask = 4'h1;
        else        m_mask[d] = 1'b1;
        m_frame[4*d +: 4] = c;
        m_active = 1'b1;
        if (m_mask == 4'hF) begin
            m_mask = 4'h0;
            if (m_frame == m_last) m_stable = (m_stable < STABLE) ? m_stable + 1 : STABLE;
            else begin
                m_stable = 1;
                m_last   = m_frame;
            end
            if (m_stable == STABLE && m_frame != m_word) begin
                m_word = m_frame;
                exp_stb++;
            end
        end
    endfunction

    function automatic void model_idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (idle_run < TMO - 1) begin
                idle_run++;
                if (idle_run == TMO - 1) begin
                    m_active = 1'b0; m_mask = '0; m_stable = 0;
                    if (m_word != 16'hFFFF) exp_stb++;
                    m_word = 16'hFFFF;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_word"},   word,             m_word);
        check({tag, "_stb"},    16'(stb_seen),    16'(exp_stb));
        check({tag, "_err"},    16'(err_seen),    16'(exp_err));
        check({tag, "_active"}, 16'(active),      16'(m_active));
        $display("frame %s: word=%h stb=%0d err=%0d active=%0b", tag, word, stb_seen, err_seen, active);
    endtask

    // Drive an anode/segment pair for n cycles and advance the model
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        int d = 0;
        an = a; seg = s;
        repeat (n) @(negedge clk);
        if ($countones(~a) == 1) begin
            idle_run = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) d = i;
            if (n >= SETTLE) model_capture(d, ref_decode(s));
        end else begin
            model_idle(n);
        end
    endtask

    task automatic idle(input int n);
        logic [3:0] a;
        case ($urandom_range(0, 2))
            0:       a = 4'hF;
            1:       a = 4'h0;
            default: a = 4'h3;
        endcase
        hold(a, 7'($urandom), n);
    endtask

    task automatic scan_digit(input int d, input logic [6:0] s, input int n);
        logic [3:0] a = ~(4'b0001 << d);
        hold(a, s, n);
    endtask

    task automatic scan_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        scan_digit(0, s0, SETTLE);
        scan_digit(1, s1, SETTLE);
        scan_digit(2, s2, SETTLE);
        scan_digit(3, s3, SETTLE);
        idle(3);
    endtask

    initial begin
        rst = 1'b1; an = 4'hF; seg = S_BL;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_word",   word,          16'hFFFF);
        check("rst_stb",    16'(word_stb), 16'h0);
        check("rst_active", 16'(active),   16'h0);
        check("rst_err",    16'(err),      16'h0);
        idle(2);

        // FULL twice, with exact publish latency on the second frame
        scan_frame(S_L, S_L, S_U, S_F);
        check_state("t1_f1");
        scan_digit(0, S_L, SETTLE);
        scan_digit(1, S_L, SETTLE);
        scan_digit(2, S_U, SETTLE);
        scan_digit(3, S_F, SETTLE);
        check("t1_before_pub", word, 16'hFFFF);
        @(negedge clk);
        check("t1_pub_word", word,          16'h2100);
        check("t1_pub_stb",  16'(word_stb), 16'h1);
        idle(3);
        check_state("t1_f2");

        // OPEN once then FULL twice: no change of the published word
        scan_frame(S_N, S_E, S_P, S_O);
        check_state("t2_open");
        scan_frame(S_L, S_L, S_U, S_F);
        scan_frame(S_L, S_L, S_U, S_F);
        check_state("t2_full");
        check("t2_word",      word,           16'h2100);
        check("t2_stb_total", 16'(stb_seen),  16'h1);

        // Digit 1 dwells one cycle short of settling
        scan_digit(0, S_L, SETTLE);
        scan_digit(1, S_L, SETTLE - 1);
        scan_digit(2, S_U, SETTLE);
        scan_digit(3, S_F, SETTLE);
        idle(3);
        check_state("t3_short");

        // Invalid segment pattern on digit 2
        scan_frame(S_L, S_L, S_BAD, S_F);
        scan_frame(S_L, S_L, S_BAD, S_F);
        check_state("t4_bad");
        check("t4_word",      word,          16'h2E00);
        check("t4_err_total", 16'(err_seen), 16'h3);

        // Aborted frame, then restart at digit 0
        scan_digit(0, S_L, SETTLE);
        scan_digit(1, S_U, SETTLE);
        scan_frame(S_L, S_L, S_U, S_P);
        scan_frame(S_L, S_L, S_U, S_P);
        check_state("t5_abort");
        check("t5_word", word, 16'h4100);

        // Reset in the middle of a frame
        scan_digit(0, S_N, SETTLE);
        scan_digit(1, S_E, SETTLE);
        an = 4'hF;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_state("mr_reset");
        scan_frame(S_L, S_L, S_U, S_F);
        check_state("mr_f1");
        scan_frame(S_L, S_L, S_U, S_F);
        check_state("mr_f2");

        // OPEN published, then the bus goes idle until timeout
        scan_frame(S_N, S_E, S_P, S_O);
        scan_frame(S_N, S_E, S_P, S_O);
        check("t6_word", word, 16'h3456);
        hold(4'hF, S_BL, 1000);
        check_state("t6_pre_timeout");
        hold(4'hF, S_BL, 30);
        check_state("t6_timeout");
        check("t6_idle_word", word, 16'hFFFF);

        // Random scans: repeated frames, short dwells, partial frames, gaps
        for (int f = 0; f < 40; f++) begin
            if (f == 0 || $urandom_range(0, 1) == 0) begin
                for (int d = 0; d < 4; d++) begin
                    int k = $urandom_range(0, 8);
                    rf[d] = (k == 8) ? 7'($urandom) : seg_tab[k];
                end
            end
            nd = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4;
            for (int d = 0; d < nd; d++) begin
                dw = ($urandom_range(0, 9) == 0) ? SETTLE - 1 : $urandom_range(SETTLE, SETTLE + 2);
                scan_digit(d, rf[d], dw);
                gp = $urandom_range(0, 2);
                if (gp > 0 && d < nd - 1) idle(gp);
            end
            idle($urandom_range(2, 6));
            check_state($sformatf("rnd%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
